// File: rtl/alarm_pkg.sv
// Shared alarm/time-counter definitions: state encoding, time limits and field widths.
// Reused by the 24 h time counter so both agree on hour/minute formats.
package alarm_pkg;

    localparam int HOUR_W = 6;
    localparam int MIN_W  = 7;
    localparam int TMR_W  = 6;
    localparam int CNT_W  = 2;

    localparam logic [HOUR_W-1:0] MAX_HOUR = 6'd23;
    localparam logic [MIN_W-1:0]  MAX_MIN  = 7'd59;

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_RINGING  = 2'd2,
        ST_SNOOZING = 2'd3
    } alarm_state_e;

    function automatic logic time_valid(input logic [HOUR_W-1:0] h, input logic [MIN_W-1:0] m);
        return (h <= MAX_HOUR) && (m <= MAX_MIN);
    endfunction

endpackage

// File: rtl/alarm_ctrl.sv
// Alarm clock controller: arm/match/ring/snooze/timeout FSM driven by minute events.
// All outputs registered; ring and state follow a minute match one cycle later.
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int SNOOZE_MIN = 9,
    parameter int RING_MIN   = 5,
    parameter int MAX_SNOOZE = 3
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [5:0] hour,
    input  logic [6:0] min,
    input  logic       set_en,
    input  logic [5:0] set_hour,
    input  logic [6:0] set_min,
    input  logic       arm,
    input  logic       snooze,
    input  logic       stop,
    output logic       ring,
    output logic [1:0] state,
    output logic [1:0] snooze_cnt,
    output logic       missed,
    output logic       set_err
);

    localparam logic [TMR_W-1:0] SNOOZE_LD  = TMR_W'(SNOOZE_MIN);
    localparam logic [TMR_W-1:0] RING_LAST  = TMR_W'(RING_MIN - 1);
    localparam logic [CNT_W-1:0] SNOOZE_LIM = CNT_W'(MAX_SNOOZE);

    alarm_state_e      state_q;
    logic              ring_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              missed_q;
    logic              set_err_q;
    logic [HOUR_W-1:0] al_hour_q;
    logic [MIN_W-1:0]  al_min_q;
    logic [MIN_W-1:0]  min_q;
    logic              arm_q;
    logic [TMR_W-1:0]  ring_tmr_q;
    logic [TMR_W-1:0]  snz_tmr_q;

    logic mev;
    logic set_ok;
    logic match;
    logic active;

    // min_q resets to the counter's reset value, so no minute event right after reset
    assign mev    = (min != min_q);
    assign set_ok = set_en && time_valid(set_hour, set_min);
    assign match  = mev && (hour == al_hour_q) && (min == al_min_q);
    assign active = (state_q == ST_RINGING) || (state_q == ST_SNOOZING);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_DISARMED;
            ring_q     <= 1'b0;
            cnt_q      <= '0;
            missed_q   <= 1'b0;
            set_err_q  <= 1'b0;
            al_hour_q  <= '0;
            al_min_q   <= '0;
            min_q      <= '0;
            arm_q      <= 1'b0;
            ring_tmr_q <= '0;
            snz_tmr_q  <= '0;
        end else begin
            min_q     <= min;
            arm_q     <= arm;
            set_err_q <= set_en && !set_ok;
            if (set_ok) begin
                al_hour_q <= set_hour;
                al_min_q  <= set_min;
            end
            if (arm && !arm_q) begin
                missed_q <= 1'b0;
            end

            if (!arm) begin
                state_q <= ST_DISARMED;
                ring_q  <= 1'b0;
                cnt_q   <= '0;
            end else if (set_ok && active) begin
                state_q <= ST_ARMED;
                ring_q  <= 1'b0;
                cnt_q   <= '0;
            end else if (stop && active) begin
                state_q  <= ST_ARMED;
                ring_q   <= 1'b0;
                cnt_q    <= '0;
                missed_q <= 1'b0;
            end else begin
                unique case (state_q)
                    ST_DISARMED: state_q <= ST_ARMED;
                    ST_ARMED: begin
                        if (match) begin
                            state_q    <= ST_RINGING;
                            ring_q     <= 1'b1;
                            ring_tmr_q <= '0;
                        end
                    end
                    ST_RINGING: begin
                        if (snooze && (cnt_q < SNOOZE_LIM)) begin
                            state_q   <= ST_SNOOZING;
                            ring_q    <= 1'b0;
                            cnt_q     <= cnt_q + 2'd1;
                            snz_tmr_q <= SNOOZE_LD;
                        end else if (mev) begin
                            if (ring_tmr_q == RING_LAST) begin
                                state_q  <= ST_ARMED;
                                ring_q   <= 1'b0;
                                cnt_q    <= '0;
                                missed_q <= 1'b1;
                            end else begin
                                ring_tmr_q <= ring_tmr_q + 6'd1;
                            end
                        end
                    end
                    ST_SNOOZING: begin
                        if (mev) begin
                            if (snz_tmr_q == 6'd1) begin
                                state_q    <= ST_RINGING;
                                ring_q     <= 1'b1;
                                ring_tmr_q <= '0;
                                snz_tmr_q  <= '0;
                            end else begin
                                snz_tmr_q <= snz_tmr_q - 6'd1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign ring       = ring_q;
    assign state      = state_q;
    assign snooze_cnt = cnt_q;
    assign missed     = missed_q;
    assign set_err    = set_err_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Scenario bench for alarm_ctrl: expected output vectors are queued with each stimulus
// step and popped/compared once the DUT has registered the response.
module tb_alarm_ctrl;

    logic       clk = 1'b0;
    logic       rstn;
    logic [5:0] hour;
    logic [6:0] min;
    logic       set_en;
    logic [5:0] set_hour;
    logic [6:0] set_min;
    logic       arm;
    logic       snooze;
    logic       stop;
    logic       ring;
    logic [1:0] state;
    logic [1:0] snooze_cnt;
    logic       missed;
    logic       set_err;

    int vecs = 0;
    int errs = 0;

    typedef struct {
        logic [6:0] v;
        string      name;
    } exp_t;

    exp_t sb[$];

    alarm_ctrl dut (
        .clk(clk), .rstn(rstn), .hour(hour), .min(min),
        .set_en(set_en), .set_hour(set_hour), .set_min(set_min),
        .arm(arm), .snooze(snooze), .stop(stop),
        .ring(ring), .state(state), .snooze_cnt(snooze_cnt),
        .missed(missed), .set_err(set_err)
    );

    always #5 clk = ~clk;

    // {state, ring, snooze_cnt, missed, set_err}
    function automatic logic [6:0] obs();
        return {state, ring, snooze_cnt, missed, set_err};
    endfunction

    function automatic logic [6:0] ev(input logic [1:0] st, input logic rg, input logic [1:0] cnt,
                                      input logic ms, input logic se);
        return {st, rg, cnt, ms, se};
    endfunction

    task automatic step(input string nm, input logic [6:0] v);
        sb.push_back('{v, nm});
        @(posedge clk);
        #1;
        set_en = 1'b0;
        snooze = 1'b0;
        stop   = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        #3;
        sb.push_back('{ev(0, 0, 0, 0, 0), "reset_async"});
        e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin errs++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
        step("reset_held", ev(0, 0, 0, 0, 0)); e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin errs++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
        arm  = 1'b1;
        rstn = 1'b1;
        step("arm_after_reset", ev(1, 0, 0, 0, 0)); e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin errs++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
        for (int i = 0; i < 3; i++) begin
            step("no_match_after_reset", ev(1, 0, 0, 0, 0)); e = sb.pop_front(); vecs++;
            if (obs() !== e.v) begin errs++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
        end
    endtask

    task automatic test_basic_ring();
        exp_t e;
        set_en = 1'b1; set_hour = 6'd6; set_min = 7'd30;
        step("set_0630", ev(1, 0, 0, 0, 0)); e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin errs++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
        hour = 6'd6; min = 7'd29;
        step("time_0629", ev(1, 0, 0, 0, 0)); e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin errs++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
        min = 7'd30;
        step("time_0630_ring", ev(2, 1, 0, 0, 0)); e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin errs++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
        step("ring_holds", ev(2, 1, 0, 0, 0)); e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin errs++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
    endtask

    task automatic test_snooze();
        exp_t e;
        for (int k = 1; k <= 3; k++) begin
            snooze = 1'b1;
            step($sformatf("snooze_%0d", k), ev(3, 0, 2'(k), 0, 0)); e = sb.pop_front(); vecs++;
            if (obs() !== e.v) begin errs++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
            for (int i = 1; i <= 9; i++) begin
                min = min + 7'd1;
                step($sformatf("snooze_%0d_min_%0d", k, i),
                     ev((i == 9) ? 2'd2 : 2'd3, (i == 9), 2'(k), 0, 0));
                e = sb.pop_front(); vecs++;
                if (obs() !== e.v) begin errs++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
            end
        end
        snooze = 1'b1;
        step("snooze_4th_ignored", ev(2, 1, 3, 0, 0)); e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin errs++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
        stop = 1'b1;
        step("stop_after_snoozes", ev(1, 0, 0, 0, 0)); e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin errs++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
    endtask

    task automatic test_timeout();
        exp_t e;
        set_en = 1'b1; set_hour = 6'd7; set_min = 7'd10;
        step("set_0710", ev(1, 0, 0, 0, 0)); e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin errs++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
        hour = 6'd7; min = 7'd9;
        step("time_0709", ev(1, 0, 0, 0, 0)); e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin errs++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
        min = 7'd10;
        step("time_0710_ring", ev(2, 1, 0, 0, 0)); e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin errs++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
        for (int i = 1; i <= 5; i++) begin
            min = min + 7'd1;
            step($sformatf("ring_timer_%0d", i),
                 (i == 5) ? ev(1, 0, 0, 1, 0) : ev(2, 1, 0, 0, 0));
            e = sb.pop_front(); vecs++;
            if (obs() !== e.v) begin errs++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
        end
        arm = 1'b0;
        step("disarm_missed_holds", ev(0, 0, 0, 1, 0)); e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin errs++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
        arm = 1'b1;
        step("rearm_clears_missed", ev(1, 0, 0, 0, 0)); e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin errs++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
    endtask

    task automatic test_wrap();
        exp_t e;
        set_en = 1'b1; set_hour = 6'd0; set_min = 7'd0;
        step("set_0000", ev(1, 0, 0, 0, 0)); e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin errs++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
        hour = 6'd23; min = 7'd59;
        step("time_2359", ev(1, 0, 0, 0, 0)); e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin errs++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
        hour = 6'd0; min = 7'd0;
        step("wrap_0000_ring", ev(2, 1, 0, 0, 0)); e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin errs++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
        snooze = 1'b1;
        step("wrap_snooze", ev(3, 0, 1, 0, 0)); e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin errs++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
        stop = 1'b1;
        step("stop_in_snoozing", ev(1, 0, 0, 0, 0)); e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin errs++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
    endtask

    task automatic test_set_err();
        exp_t e;
        set_en = 1'b1; set_hour = 6'd24; set_min = 7'd0;
        step("set_2400_err", ev(1, 0, 0, 0, 1)); e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin errs++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
        step("set_err_one_cycle", ev(1, 0, 0, 0, 0)); e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin errs++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
        set_en = 1'b1; set_hour = 6'd12; set_min = 7'd60;
        step("set_1260_err", ev(1, 0, 0, 0, 1)); e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin errs++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
        hour = 6'd23; min = 7'd59;
        step("time_2359_again", ev(1, 0, 0, 0, 0)); e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin errs++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
        hour = 6'd0; min = 7'd0;
        step("alarm_kept_0000", ev(2, 1, 0, 0, 0)); e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin errs++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
        stop = 1'b1; snooze = 1'b1;
        step("stop_beats_snooze", ev(1, 0, 0, 0, 0)); e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin errs++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
    endtask

    task automatic test_priority();
        exp_t e;
        hour = 6'd23; min = 7'd59;
        step("prio_2359", ev(1, 0, 0, 0, 0)); e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin errs++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
        hour = 6'd0; min = 7'd0;
        step("prio_ring", ev(2, 1, 0, 0, 0)); e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin errs++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
        set_en = 1'b1; set_hour = 6'd5; set_min = 7'd0; snooze = 1'b1;
        step("set_in_ringing", ev(1, 0, 0, 0, 0)); e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin errs++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
        hour = 6'd4; min = 7'd59;
        step("time_0459", ev(1, 0, 0, 0, 0)); e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin errs++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
        hour = 6'd5; min = 7'd0;
        step("time_0500_ring", ev(2, 1, 0, 0, 0)); e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin errs++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
        arm = 1'b0; stop = 1'b1;
        step("disarm_beats_stop", ev(0, 0, 0, 0, 0)); e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin errs++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
        arm = 1'b1;
        step("rearm", ev(1, 0, 0, 0, 0)); e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin errs++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
    endtask

    task automatic test_reset_mid_snooze();
        exp_t e;
        set_en = 1'b1; set_hour = 6'd5; set_min = 7'd10;
        step("set_0510", ev(1, 0, 0, 0, 0)); e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin errs++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
        min = 7'd9;
        step("time_0509", ev(1, 0, 0, 0, 0)); e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin errs++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
        min = 7'd10;
        step("time_0510_ring", ev(2, 1, 0, 0, 0)); e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin errs++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
        snooze = 1'b1;
        step("snooze_before_reset", ev(3, 0, 1, 0, 0)); e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin errs++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
        #2;
        rstn = 1'b0;
        arm  = 1'b0;
        #1;
        sb.push_back('{ev(0, 0, 0, 0, 0), "reset_mid_snooze_async"});
        e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin errs++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            min = min + 7'd1;
            step($sformatf("no_ring_after_reset_%0d", i), ev(0, 0, 0, 0, 0)); e = sb.pop_front(); vecs++;
            if (obs() !== e.v) begin errs++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
        end
        arm = 1'b1;
        step("rearm_after_reset", ev(1, 0, 0, 0, 0)); e = sb.pop_front(); vecs++;
        if (obs() !== e.v) begin errs++; $display("FAIL %s: got %b expected %b", e.name, obs(), e.v); end
    endtask

    initial begin
        rstn = 1'b0; arm = 1'b0; hour = 6'd0; min = 7'd0;
        set_en = 1'b0; set_hour = 6'd0; set_min = 7'd0;
        snooze = 1'b0; stop = 1'b0;
        test_reset();
        test_basic_ring();
        test_snooze();
        test_timeout();
        test_wrap();
        test_set_err();
        test_priority();
        test_reset_mid_snooze();
        if (sb.size() != 0) begin
            errs++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
